// File: rtl/usb_axi_master_pkg.sv
// Shared types and constants for the USB-side AXI4-Lite initiator.
package usb_axi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        RSP
    } axi_mst_state_t;

    // Low address bits that must be zero for a 32-bit access.
    localparam logic [1:0] ALIGN_MASK   = 2'b11;
    localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/usb_axi_master_if.sv
// Command/response handshake plus AXI4-Lite bus of usb_axi_master, grouped as one bundle.
interface usb_axi_master_if #(
    parameter int ADDR_W = 32,
    parameter int Data_W = 32
);
    logic              Cmd_Valid;
    logic              Cmd_Ready;
    logic              Cmd_Write;
    logic [ADDR_W-1:0] Cmd_Address;
    logic [Data_W-1:0] Cmd_Data;
    logic [3:0]        Cmd_Strobe;
    logic              Rsp_Valid;
    logic              Rsp_Ready;
    logic [Data_W-1:0] Rsp_Data;
    logic              Rsp_Error;
    logic              R_Valid_Address;
    logic [ADDR_W-1:0] Read_Address_axi;
    logic [2:0]        R_Prot;
    logic              R_Ready_Address;
    logic              Read_Ready;
    logic              Valid_Data_R;
    logic [Data_W-1:0] Read_Data_axi;
    logic              R_Error;
    logic              Write_Valid;
    logic [ADDR_W-1:0] Write_Address_axi;
    logic [2:0]        W_Prot;
    logic [Data_W-1:0] Write_Data_axi;
    logic [3:0]        Write_Strobe;
    logic              Write_Ready;
    logic              W_Error;

    modport master (
        input  Cmd_Valid, Cmd_Write, Cmd_Address, Cmd_Data, Cmd_Strobe, Rsp_Ready,
        input  R_Ready_Address, Valid_Data_R, Read_Data_axi, R_Error, Write_Ready, W_Error,
        output Cmd_Ready, Rsp_Valid, Rsp_Data, Rsp_Error,
        output R_Valid_Address, Read_Address_axi, R_Prot, Read_Ready,
        output Write_Valid, Write_Address_axi, W_Prot, Write_Data_axi, Write_Strobe
    );

    modport slave (
        output Cmd_Valid, Cmd_Write, Cmd_Address, Cmd_Data, Cmd_Strobe, Rsp_Ready,
        output R_Ready_Address, Valid_Data_R, Read_Data_axi, R_Error, Write_Ready, W_Error,
        input  Cmd_Ready, Rsp_Valid, Rsp_Data, Rsp_Error,
        input  R_Valid_Address, Read_Address_axi, R_Prot, Read_Ready,
        input  Write_Valid, Write_Address_axi, W_Prot, Write_Data_axi, Write_Strobe
    );
endinterface

// File: rtl/usb_axi_master_watchdog.sv
// Bus-phase watchdog: counts enabled cycles, flags the last allowed cycle.
module axi_mst_watchdog #(
    parameter int LIMIT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int            CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && cnt_q != LAST)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expired = en && (cnt_q == LAST);
endmodule

// File: rtl/usb_axi_master.sv
// Single-outstanding AXI4-Lite initiator for the USB slave port.
// Optional bus watchdog abort: define USB_AXI_MST_TIMEOUT_EN.
module usb_axi_master
    import usb_axi_pkg::*;
#(
    parameter int         ADDR_W         = 32,
    parameter int         Data_W         = 32,
    parameter logic [2:0] PROT           = PROT_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 256
) (
    input logic              Clk_axi,
    input logic              Rst,
    usb_axi_master_if.master bus
);
    axi_mst_state_t    state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [Data_W-1:0] wdata_q, wdata_d;
    logic [3:0]        strb_q, strb_d;
    logic [Data_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              wd_expired;

`ifdef USB_AXI_MST_TIMEOUT_EN
    logic wd_en, wd_clr;
    assign wd_en  = state_q inside {WR_REQ, RD_ADDR, RD_DATA};
    assign wd_clr = (state_d != state_q);

    axi_mst_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wd (
        .clk     (Clk_axi),
        .rst_n   (Rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign wd_expired     = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        unique case (state_q)
            IDLE: if (bus.Cmd_Valid) begin
                addr_d     = bus.Cmd_Address;
                wdata_d    = bus.Cmd_Data;
                strb_d     = bus.Cmd_Strobe;
                rsp_data_d = '0;
                rsp_err_d  = 1'b0;
                // Misaligned commands never reach the bus.
                if ((bus.Cmd_Address[1:0] & ALIGN_MASK) != 2'b00) begin
                    rsp_err_d = 1'b1;
                    state_d   = RSP;
                end else begin
                    state_d = bus.Cmd_Write ? WR_REQ : RD_ADDR;
                end
            end
            WR_REQ: if (bus.Write_Ready) begin
                rsp_err_d = bus.W_Error;
                state_d   = RSP;
            end else if (wd_expired) begin
                rsp_err_d = 1'b1;
                state_d   = RSP;
            end
            // A data beat coincident with the address handshake is left for RD_DATA.
            RD_ADDR: if (bus.R_Ready_Address) begin
                state_d = RD_DATA;
            end else if (wd_expired) begin
                rsp_err_d = 1'b1;
                state_d   = RSP;
            end
            RD_DATA: if (bus.Valid_Data_R) begin
                rsp_err_d  = bus.R_Error;
                rsp_data_d = bus.R_Error ? '0 : bus.Read_Data_axi;
                state_d    = RSP;
            end else if (wd_expired) begin
                rsp_err_d = 1'b1;
                state_d   = RSP;
            end
            RSP: if (bus.Rsp_Ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk_axi or negedge Rst) begin
        if (!Rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign bus.Cmd_Ready         = (state_q == IDLE);
    assign bus.Rsp_Valid         = (state_q == RSP);
    assign bus.Rsp_Data          = rsp_data_q;
    assign bus.Rsp_Error         = rsp_err_q;
    assign bus.R_Valid_Address   = (state_q == RD_ADDR);
    assign bus.Read_Address_axi  = addr_q;
    assign bus.R_Prot            = PROT;
    assign bus.Read_Ready        = (state_q == RD_DATA);
    assign bus.Write_Valid       = (state_q == WR_REQ);
    assign bus.Write_Address_axi = addr_q;
    assign bus.W_Prot            = PROT;
    assign bus.Write_Data_axi    = wdata_q;
    assign bus.Write_Strobe      = strb_q;
endmodule
